// File: rtl/id_ex_skid_reg_if.sv
// ID->EX stage handshake bundle: decode-side inputs, EX-side outputs, stall controls and counters.
// The slave modport is the register's view; the master modport is the view of whoever drives it.
interface id_ex_skid_reg_if #(
    parameter int CTRL_W    = 16,
    parameter int PAYLOAD_W = 128,
    parameter int CNT_W     = 16
);
    logic                 flush;
    logic                 hazard;
    logic                 in_valid;
    logic                 in_ready;
    logic [CTRL_W-1:0]    in_ctrl;
    logic [PAYLOAD_W-1:0] in_payload;
    logic                 out_valid;
    logic                 out_ready;
    logic [CTRL_W-1:0]    out_ctrl;
    logic [PAYLOAD_W-1:0] out_payload;
    logic [1:0]           occupancy;
    logic                 cnt_clr;
    logic [CNT_W-1:0]     stall_cnt;
    logic [CNT_W-1:0]     bubble_cnt;
    logic [CNT_W-1:0]     flush_cnt;

    modport slave (
        input  flush, hazard, in_valid, in_ctrl, in_payload, out_ready, cnt_clr,
        output in_ready, out_valid, out_ctrl, out_payload, occupancy,
               stall_cnt, bubble_cnt, flush_cnt
    );

    modport master (
        output flush, hazard, in_valid, in_ctrl, in_payload, out_ready, cnt_clr,
        input  in_ready, out_valid, out_ctrl, out_payload, occupancy,
               stall_cnt, bubble_cnt, flush_cnt
    );
endinterface

// File: rtl/id_ex_skid_reg.sv
// ID->EX pipeline register with valid/ready handshake, 2-entry skid buffer, hazard stall,
// synchronous flush and saturating performance counters.
module id_ex_skid_reg #(
    parameter int CTRL_W      = 16,
    parameter int PAYLOAD_W   = 128,
    parameter int CNT_W       = 16,
    parameter bit CLR_PAYLOAD = 1'b0
) (
    input logic              clk,
    input logic              rst,
    id_ex_skid_reg_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                 r_main_valid;
    logic                 r_skid_valid;
    logic [CTRL_W-1:0]    r_main_ctrl;
    logic [CTRL_W-1:0]    r_skid_ctrl;
    logic [PAYLOAD_W-1:0] r_main_payload;
    logic [PAYLOAD_W-1:0] r_skid_payload;
    logic [CNT_W-1:0]     r_stall_cnt;
    logic [CNT_W-1:0]     r_bubble_cnt;
    logic [CNT_W-1:0]     r_flush_cnt;

    logic w_in_ready;
    logic w_acc;
    logic w_pop;

    // in_ready looks only at the registered skid slot, so out_ready never reaches it combinationally.
    assign w_in_ready = ~r_skid_valid & ~bus.hazard & ~bus.flush;
    assign w_acc      = bus.in_valid & w_in_ready;
    assign w_pop      = r_main_valid & bus.out_ready;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
    endfunction

    // NOTE: every register here is state, so it is written with <= only; a blocking write would
    // let later statements in the same block observe the new value and break the slot transfer.
    // NOTE: payload slots are ordinary flops, not a RAM, so they can and do take the async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid   <= 1'b0;
            r_skid_valid   <= 1'b0;
            r_main_ctrl    <= '0;
            r_skid_ctrl    <= '0;
            r_main_payload <= '0;
            r_skid_payload <= '0;
        end else if (bus.flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main_ctrl  <= '0;
            r_skid_ctrl  <= '0;
            if (CLR_PAYLOAD) begin
                r_main_payload <= '0;
                r_skid_payload <= '0;
            end
        end else if (w_pop && r_skid_valid) begin
            r_main_ctrl    <= r_skid_ctrl;
            r_main_payload <= r_skid_payload;
            r_skid_valid   <= 1'b0;
            r_skid_ctrl    <= '0;
        end else if (w_acc && (!r_main_valid || w_pop)) begin
            r_main_valid   <= 1'b1;
            r_main_ctrl    <= bus.in_ctrl;
            r_main_payload <= bus.in_payload;
        end else if (w_acc) begin
            r_skid_valid   <= 1'b1;
            r_skid_ctrl    <= bus.in_ctrl;
            r_skid_payload <= bus.in_payload;
        end else if (w_pop) begin
            // Ctrl of a vacated slot is cleared so a stale command can never resurface.
            r_main_valid <= 1'b0;
            r_main_ctrl  <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else if (bus.cnt_clr) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            r_stall_cnt  <= sat_inc(r_stall_cnt, bus.in_valid & ~w_in_ready & ~bus.flush);
            r_bubble_cnt <= sat_inc(r_bubble_cnt, bus.out_ready & ~r_main_valid);
            r_flush_cnt  <= sat_inc(r_flush_cnt, bus.flush);
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_main_valid;
    assign bus.out_ctrl    = r_main_valid ? r_main_ctrl : '0;
    assign bus.out_payload = r_main_payload;
    assign bus.occupancy   = {1'b0, r_main_valid} + {1'b0, r_skid_valid};
    assign bus.stall_cnt   = r_stall_cnt;
    assign bus.bubble_cnt  = r_bubble_cnt;
    assign bus.flush_cnt   = r_flush_cnt;
endmodule
